// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - fixed-latency instruction memory responder with preload write port
// Serves one fetch read per LATENCY cycles; writes and new reads are accepted only when not stalled.
module imem_responder #(
  parameter int N          = 16,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rd,
  input  logic         wr,
  input  logic [N-1:0] addr,
  input  logic [N-1:0] data_in,
  output logic [N-1:0] data_out,
  output logic         done,
  output logic         stall,
  output logic         err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic [DEPTH_LOG2-1:0] idx, idx_nxt;
  logic [N-1:0]          dout_nxt;
  logic                  err_nxt;
  logic                  mem_we;
  logic [N-1:0]          mem [2**DEPTH_LOG2];

  logic [DEPTH_LOG2-1:0] addr_idx;
  logic                  unused_addr;

  // Upper address bits alias; they are deliberately dropped.
  assign addr_idx    = addr[DEPTH_LOG2:1];
  assign unused_addr = ^addr[N-1:DEPTH_LOG2+1];

  assign stall = (state == BUSY);
  assign done  = (state == RESP);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    dout_nxt  = data_out;
    err_nxt   = 1'b0;
    mem_we    = 1'b0;
    case (state)
      BUSY: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
          dout_nxt  = mem[idx];
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: begin
        // IDLE and RESP accept requests identically, allowing back-to-back reads.
        state_nxt = IDLE;
        if (rd || wr) begin
          if ((rd && wr) || addr[0]) begin
            err_nxt = 1'b1;
          end else if (wr) begin
            mem_we = 1'b1;
          end else begin
            idx_nxt = addr_idx;
            if (LATENCY == 1) begin
              state_nxt = RESP;
              dout_nxt  = mem[addr_idx];
            end else begin
              state_nxt = BUSY;
              cnt_nxt   = CNT_INIT;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      idx      <= '0;
      data_out <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      data_out <= dout_nxt;
      err      <= err_nxt;
    end
  end

  // Array contents survive reset and are undefined until preloaded.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_idx] <= data_in;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - randomized and directed check of imem_responder against a reference model
module tb_imem_responder;

  localparam int N   = 16;
  localparam int DL  = 8;
  localparam int LAT = 3;

  logic         clk;
  logic         rst;
  logic         rd;
  logic         wr;
  logic [N-1:0] addr;
  logic [N-1:0] data_in;
  logic [N-1:0] data_out;
  logic         done;
  logic         stall;
  logic         err;

  imem_responder #(.N(N), .DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .rd       (rd),
    .wr       (wr),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .done     (done),
    .stall    (stall),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: word array plus "cycles remaining until response".
  logic [N-1:0] mref [2**DL];
  int           left;
  logic [N-1:0] pend_data;
  logic [N-1:0] dout_exp;
  logic         err_exp;

  int vectors;
  int miscompares;

  task automatic model_reset();
    left     = -1;
    dout_exp = '0;
    err_exp  = 1'b0;
  endtask

  task automatic model_edge(input logic r, input logic w, input logic [N-1:0] a, input logic [N-1:0] d);
    err_exp = 1'b0;
    if (left > 0) begin
      left = left - 1;
    end else begin
      left = -1;
      if (r || w) begin
        if ((r && w) || a[0]) err_exp = 1'b1;
        else if (w) mref[a[DL:1]] = d;
        else begin
          pend_data = mref[a[DL:1]];
          left      = LAT - 1;
        end
      end
    end
    if (left == 0) dout_exp = pend_data;
  endtask

  task automatic chk(input string tag);
    logic [N+2:0] obs;
    logic [N+2:0] exp;
    obs = {done, stall, err, data_out};
    exp = {(left == 0), (left > 0), err_exp, dout_exp};
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed done/stall/err/data=%b/%b/%b/%h expected %b/%b/%b/%h",
             tag, obs[N+2], obs[N+1], obs[N], obs[N-1:0], exp[N+2], exp[N+1], exp[N], exp[N-1:0]);
    end
  endtask

  // Inputs applied at the falling edge, outputs checked at the next falling edge.
  task automatic cyc(input logic r, input logic w, input logic [N-1:0] a, input logic [N-1:0] d,
                     input string tag);
    rd = r; wr = w; addr = a; data_in = d;
    @(posedge clk);
    model_edge(r, w, a, d);
    @(negedge clk);
    chk(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0000, 16'h0000, tag);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
    for (int i = 0; i < 2**DL; i++) mref[i] = 'x;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_state");
    rst = 1'b1;

    for (int i = 0; i < 2**DL; i++) cyc(1'b0, 1'b1, 16'(i * 2), 16'($urandom), "preload");

    cyc(1'b0, 1'b1, 16'h0000, 16'h1234, "wr_0000");
    cyc(1'b0, 1'b1, 16'h0010, 16'hBEEF, "wr_0010");
    cyc(1'b1, 1'b0, 16'h0010, 16'h0000, "rd_0010");
    idle(4, "single_read");

    cyc(1'b0, 1'b1, 16'h0002, 16'h1111, "wr_0002");
    cyc(1'b0, 1'b1, 16'h0004, 16'h2222, "wr_0004");
    cyc(1'b1, 1'b0, 16'h0002, 16'h0000, "rd_0002");
    cyc(1'b1, 1'b0, 16'h0004, 16'h0000, "rd_during_stall");
    idle(1, "b2b_wait");
    cyc(1'b1, 1'b0, 16'h0004, 16'h0000, "rd_in_done");
    idle(4, "b2b_second");

    cyc(1'b1, 1'b0, 16'h0003, 16'h0000, "rd_misaligned");
    idle(2, "after_misaligned");
    cyc(1'b1, 1'b1, 16'h0000, 16'hDEAD, "rd_wr_both");
    idle(1, "after_both");
    cyc(1'b1, 1'b0, 16'h0000, 16'h0000, "rd_0000_unchanged");
    idle(3, "readback_0000");

    cyc(1'b0, 1'b1, 16'h0020, 16'hCAFE, "wr_0020");
    cyc(1'b1, 1'b0, 16'h0220, 16'h0000, "rd_alias_0220");
    idle(3, "alias");

    cyc(1'b1, 1'b0, 16'h0010, 16'h0000, "rd_before_reset");
    rst = 1'b0;
    #1;
    model_reset();
    chk("async_reset_mid_access");
    @(negedge clk);
    rst = 1'b1;
    idle(5, "no_done_after_reset");

    for (int i = 0; i < 400; i++) begin
      logic         r;
      logic         w;
      logic [N-1:0] a;
      r = ($urandom_range(0, 2) == 0);
      w = ($urandom_range(0, 3) == 0);
      a = 16'($urandom);
      if ($urandom_range(0, 7) != 0) a[0] = 1'b0;
      cyc(r, w, a, 16'($urandom), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
